// File: rtl/pcs_pkg.sv
// rtl/pcs_pkg.sv - shared 1000BASE-X PCS code-group constants and scheduler states
package pcs_pkg;

  // Code-group octets (K flag carried separately on the encoder interface)
  localparam logic [7:0] K28_5   = 8'hBC;
  localparam logic [7:0] D21_5   = 8'hB5;
  localparam logic [7:0] D2_2    = 8'h42;
  localparam logic [7:0] D5_6    = 8'hC5;
  localparam logic [7:0] D16_2   = 8'h50;
  localparam logic [7:0] K27_7_S = 8'hFB;
  localparam logic [7:0] K29_7_T = 8'hFD;
  localparam logic [7:0] K23_7_R = 8'hF7;
  localparam logic [7:0] K30_7_V = 8'hFE;

  // Transmit scheduler states. ST_START is only ever entered as the
  // decision for the current cycle; the stored state after it is ST_DATA.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CFG    = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_END_R  = 3'd4,
    ST_END_R2 = 3'd5
  } tx_state_t;

endpackage

// File: rtl/pcs_tx_sched.sv
// rtl/pcs_tx_sched.sv - 1000BASE-X PCS transmit code-group scheduler
//
// Selects one code-group per tx_clk among /C/ config sets, /I/ idle sets and
// framed MAC data (/S/ data /T/ /R/ [/R/]), keeping ordered sets and /S/ on
// even positions and requiring an /I/ before every frame.
//
// Ports:
//   tx_clk     in   transmit clock
//   rst        in   asynchronous active-high reset
//   lacr_send  in   request /C/ ordered sets
//   lacr_out   in   16-bit config register carried in /C/
//   operate    in   link up, MAC frames allowed to start
//   rd_pos     in   encoder running disparity is positive
//   mac_tx_en  in   MAC frame valid, high for the whole frame
//   mac_txd    in   MAC byte
//   mac_tx_er  in   MAC error marker
//   mac_ack    out  mac_txd consumed this cycle (combinational)
//   txd        out  registered code-group octet
//   txk        out  registered K flag for txd
//
// Build option: define PCS_TX_ER_EN to map mac_tx_er onto /V/ (K30.7) in
// DATA; otherwise mac_tx_er is ignored.
module pcs_tx_sched
  import pcs_pkg::*;
(
  input  logic        tx_clk,
  input  logic        rst,
  input  logic        lacr_send,
  input  logic [15:0] lacr_out,
  input  logic        operate,
  input  logic        rd_pos,
  input  logic        mac_tx_en,
  input  logic [7:0]  mac_txd,
  input  logic        mac_tx_er,
  output logic        mac_ack,
  output logic [7:0]  txd,
  output logic        txk
);

  tx_state_t   r_state;
  logic [1:0]  r_idx;       // byte index within the current ordered set
  logic        r_pos;       // parity of the byte being chosen this cycle
  logic        r_gap_ok;    // an /I/ has been sent since the last frame or /C/
  logic        r_cfg_alt;   // 0: next /C/ is /C1/, 1: /C2/
  logic [15:0] r_cfg_hold;  // lacr_out captured at /C/ byte 0
  logic        r_rd_hold;   // rd_pos captured at /I/ byte 0
  logic [7:0]  r_txd;
  logic        r_txk;

  tx_state_t   w_cur;
  tx_state_t   w_nxt_state;
  logic [1:0]  w_nxt_idx;
  logic        w_bnd;
  logic        w_tx_er;
  logic [7:0]  w_txd;
  logic        w_txk;
  logic        w_gap_ok;
  logic        w_cfg_alt;
  logic [15:0] w_cfg_hold;
  logic        w_rd_hold;
  logic        w_ack;

`ifdef PCS_TX_ER_EN
  assign w_tx_er = mac_tx_er;
`else
  // Port kept for a uniform interface; the AND keeps it read but inert.
  assign w_tx_er = mac_tx_er & 1'b0;
`endif

  // A new set may begin only after a complete /I/ or /C/ (or a finished
  // frame, which always returns to ST_IDLE at index 0 on an even position).
  assign w_bnd = (r_idx == 2'd0) && ((r_state == ST_IDLE) || (r_state == ST_CFG));

  always_comb begin
    w_cur = r_state;
    if (w_bnd) begin
      if (lacr_send)
        w_cur = ST_CFG;
      else if (operate && mac_tx_en && r_gap_ok)
        w_cur = ST_START;
      else
        w_cur = ST_IDLE;
    end
  end

  always_comb begin
    w_nxt_state = w_cur;
    w_nxt_idx   = r_idx;
    w_txd       = K28_5;
    w_txk       = 1'b1;
    w_gap_ok    = r_gap_ok;
    w_cfg_alt   = r_cfg_alt;
    w_cfg_hold  = r_cfg_hold;
    w_rd_hold   = r_rd_hold;
    w_ack       = 1'b0;

    case (w_cur)
      ST_IDLE: begin
        if (r_idx == 2'd0) begin
          w_txd     = K28_5;
          w_txk     = 1'b1;
          w_rd_hold = rd_pos;
          w_nxt_idx = 2'd1;
        end else begin
          w_txd     = r_rd_hold ? D5_6 : D16_2;
          w_txk     = 1'b0;
          w_nxt_idx = 2'd0;
          w_gap_ok  = 1'b1;
        end
      end

      ST_CFG: begin
        w_txk = 1'b0;
        case (r_idx)
          2'd0: begin
            w_txd      = K28_5;
            w_txk      = 1'b1;
            w_cfg_hold = lacr_out;
            w_gap_ok   = 1'b0;
          end
          2'd1:    w_txd = r_cfg_alt ? D2_2 : D21_5;
          2'd2:    w_txd = r_cfg_hold[7:0];
          default: begin
            w_txd     = r_cfg_hold[15:8];
            w_cfg_alt = ~r_cfg_alt;
          end
        endcase
        w_nxt_idx = r_idx + 2'd1;
      end

      ST_START: begin
        // First preamble byte is consumed and replaced by /S/.
        w_txd       = K27_7_S;
        w_txk       = 1'b1;
        w_ack       = 1'b1;
        w_gap_ok    = 1'b0;
        w_nxt_state = ST_DATA;
        w_nxt_idx   = 2'd0;
      end

      ST_DATA: begin
        if (mac_tx_en) begin
          w_ack = 1'b1;
          w_txd = w_tx_er ? K30_7_V : mac_txd;
          w_txk = w_tx_er;
        end else begin
          w_txd       = w_tx_er ? K30_7_V : K29_7_T;
          w_txk       = 1'b1;
          w_nxt_state = ST_END_R;
        end
      end

      ST_END_R: begin
        w_txd    = K23_7_R;
        w_txk    = 1'b1;
        w_gap_ok = 1'b0;
        // This /R/ sits on r_pos; if it is even the following byte would be
        // odd, so a second /R/ realigns the next ordered set.
        w_nxt_state = r_pos ? ST_IDLE : ST_END_R2;
        w_nxt_idx   = 2'd0;
      end

      ST_END_R2: begin
        w_txd       = K23_7_R;
        w_txk       = 1'b1;
        w_nxt_state = ST_IDLE;
        w_nxt_idx   = 2'd0;
      end

      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_idx   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= 2'd0;
      r_pos      <= 1'b0;
      r_gap_ok   <= 1'b0;
      r_cfg_alt  <= 1'b0;
      r_cfg_hold <= 16'h0000;
      r_rd_hold  <= 1'b0;
      r_txd      <= K28_5;
      r_txk      <= 1'b1;
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_pos      <= ~r_pos;
      r_gap_ok   <= w_gap_ok;
      r_cfg_alt  <= w_cfg_alt;
      r_cfg_hold <= w_cfg_hold;
      r_rd_hold  <= w_rd_hold;
      r_txd      <= w_txd;
      r_txk      <= w_txk;
    end
  end

  assign mac_ack = w_ack;
  assign txd     = r_txd;
  assign txk     = r_txk;

endmodule

// File: tb/tb_pcs_tx_sched.sv
// tb/tb_pcs_tx_sched.sv - directed table-driven bench for pcs_tx_sched
module tb_pcs_tx_sched;

  logic        tx_clk = 1'b0;
  logic        rst;
  logic        lacr_send;
  logic [15:0] lacr_out;
  logic        operate;
  logic        rd_pos;
  logic        mac_tx_en;
  logic [7:0]  mac_txd;
  logic        mac_tx_er;
  logic        mac_ack;
  logic [7:0]  txd;
  logic        txk;

  pcs_tx_sched dut (
    .tx_clk    (tx_clk),
    .rst       (rst),
    .lacr_send (lacr_send),
    .lacr_out  (lacr_out),
    .operate   (operate),
    .rd_pos    (rd_pos),
    .mac_tx_en (mac_tx_en),
    .mac_txd   (mac_txd),
    .mac_tx_er (mac_tx_er),
    .mac_ack   (mac_ack),
    .txd       (txd),
    .txk       (txk)
  );

  always #4 tx_clk = ~tx_clk;

`ifdef PCS_TX_ER_EN
  localparam bit ER_EN = 1'b1;
`else
  localparam bit ER_EN = 1'b0;
`endif

  localparam logic [15:0] LO = 16'h01A0;

  typedef struct {
    logic        ls;
    logic [15:0] lo;
    logic        op;
    logic        rd;
    logic        en;
    logic [7:0]  d;
    logic        er;
    logic        ack;
    logic        k;
    logic [7:0]  x;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic add(input logic ls, input logic [15:0] lo, input logic op,
                     input logic rd, input logic en, input logic [7:0] d,
                     input logic er, input logic ack, input logic k,
                     input logic [7:0] x);
    vec_t v;
    v.ls = ls; v.lo = lo; v.op = op; v.rd = rd; v.en = en; v.d = d;
    v.er = er; v.ack = ack; v.k = k; v.x = x;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
  endtask

  initial begin
    rst = 1'b1; lacr_send = 1'b0; lacr_out = LO; operate = 1'b0; rd_pos = 1'b0;
    mac_tx_en = 1'b0; mac_txd = 8'h00; mac_tx_er = 1'b0;

    //   ls  lo       op rd en d      er ack k  x
    // idle, rd_pos captured at byte 0
    add(0, LO,      0, 0, 0, 8'h00, 0, 0, 1, 8'hBC);  // 0
    add(0, LO,      0, 0, 0, 8'h00, 0, 0, 0, 8'h50);
    add(0, LO,      0, 1, 0, 8'h00, 0, 0, 1, 8'hBC);
    add(0, LO,      0, 0, 0, 8'h00, 0, 0, 0, 8'hC5);
    // /C1/ /C2/ /C1/, lacr_out held across the set
    add(1, LO,      0, 0, 0, 8'h00, 0, 0, 1, 8'hBC);  // 4
    add(1, LO,      0, 0, 0, 8'h00, 0, 0, 0, 8'hB5);
    add(1, LO,      0, 0, 0, 8'h00, 0, 0, 0, 8'hA0);
    add(1, LO,      0, 0, 0, 8'h00, 0, 0, 0, 8'h01);
    add(1, LO,      0, 0, 0, 8'h00, 0, 0, 1, 8'hBC);  // 8
    add(1, LO,      0, 0, 0, 8'h00, 0, 0, 0, 8'h42);
    add(1, LO,      0, 0, 0, 8'h00, 0, 0, 0, 8'hA0);
    add(1, LO,      0, 0, 0, 8'h00, 0, 0, 0, 8'h01);
    add(1, LO,      0, 0, 0, 8'h00, 0, 0, 1, 8'hBC);  // 12
    add(1, 16'hFFFF,0, 0, 0, 8'h00, 0, 0, 0, 8'hB5);
    add(0, 16'hFFFF,0, 0, 0, 8'h00, 0, 0, 0, 8'hA0);
    add(0, 16'hFFFF,0, 0, 0, 8'h00, 0, 0, 0, 8'h01);
    add(0, LO,      0, 0, 0, 8'h00, 0, 0, 1, 8'hBC);  // 16
    add(0, LO,      0, 0, 0, 8'h00, 0, 0, 0, 8'h50);
    // 8-byte frame 55x7 D5, tx_er pulse on byte 4
    add(0, LO,      1, 0, 1, 8'h55, 0, 1, 1, 8'hFB);  // 18
    add(0, LO,      1, 0, 1, 8'h55, 0, 1, 0, 8'h55);
    add(0, LO,      1, 0, 1, 8'h55, 0, 1, 0, 8'h55);
    add(0, LO,      1, 0, 1, 8'h55, 0, 1, 0, 8'h55);
    add(0, LO,      1, 0, 1, 8'h55, 1, 1, ER_EN, ER_EN ? 8'hFE : 8'h55);
    add(0, LO,      1, 0, 1, 8'h55, 0, 1, 0, 8'h55);
    add(0, LO,      1, 0, 1, 8'h55, 0, 1, 0, 8'h55);
    add(0, LO,      1, 0, 1, 8'hD5, 0, 1, 0, 8'hD5);  // 25
    add(0, LO,      1, 0, 0, 8'h00, 0, 0, 1, 8'hFD);  // T even
    add(0, LO,      1, 0, 0, 8'h00, 0, 0, 1, 8'hF7);
    // back-to-back request held off by one /I/
    add(0, LO,      1, 0, 1, 8'hAA, 0, 0, 1, 8'hBC);  // 28
    add(0, LO,      1, 0, 1, 8'hAA, 0, 0, 0, 8'h50);
    add(0, LO,      1, 0, 1, 8'hAA, 0, 1, 1, 8'hFB);  // 30
    add(0, LO,      1, 0, 1, 8'h11, 0, 1, 0, 8'h11);
    add(0, LO,      1, 0, 1, 8'h22, 0, 1, 0, 8'h22);
    add(0, LO,      1, 0, 0, 8'h00, 1, 0, 1, ER_EN ? 8'hFE : 8'hFD); // odd
    add(0, LO,      1, 0, 0, 8'h00, 0, 0, 1, 8'hF7);
    add(0, LO,      1, 0, 0, 8'h00, 0, 0, 1, 8'hF7);  // 35 extra /R/
    add(0, LO,      1, 0, 0, 8'h00, 0, 0, 1, 8'hBC);
    add(0, LO,      1, 0, 0, 8'h00, 0, 0, 0, 8'h50);
    // lacr_send rises mid-frame
    add(0, LO,      1, 0, 1, 8'hAA, 0, 1, 1, 8'hFB);  // 38
    add(1, LO,      1, 0, 1, 8'h01, 0, 1, 0, 8'h01);
    add(1, LO,      1, 0, 1, 8'h02, 0, 1, 0, 8'h02);
    add(1, LO,      1, 0, 1, 8'h03, 0, 1, 0, 8'h03);
    add(1, LO,      1, 0, 0, 8'h00, 0, 0, 1, 8'hFD);
    add(1, LO,      1, 0, 0, 8'h00, 0, 0, 1, 8'hF7);
    add(1, LO,      1, 0, 0, 8'h00, 0, 0, 1, 8'hBC);  // 44
    add(0, LO,      1, 0, 0, 8'h00, 0, 0, 0, 8'h42);
    add(0, LO,      1, 0, 0, 8'h00, 0, 0, 0, 8'hA0);
    add(0, LO,      1, 0, 0, 8'h00, 0, 0, 0, 8'h01);
    // mac_tx_en while operate=0 is ignored
    add(0, LO,      0, 0, 1, 8'hAA, 0, 0, 1, 8'hBC);  // 48
    add(0, LO,      0, 0, 1, 8'hAA, 0, 0, 0, 8'h50);
    add(0, LO,      0, 0, 1, 8'hAA, 0, 0, 1, 8'hBC);
    add(0, LO,      0, 0, 1, 8'hAA, 0, 0, 0, 8'h50);
    // operate falls mid-frame, frame completes
    add(0, LO,      1, 0, 1, 8'hAA, 0, 1, 1, 8'hFB);  // 52
    add(0, LO,      0, 0, 1, 8'h77, 0, 1, 0, 8'h77);
    add(0, LO,      0, 0, 0, 8'h00, 0, 0, 1, 8'hFD);
    add(0, LO,      0, 0, 0, 8'h00, 0, 0, 1, 8'hF7);
    add(0, LO,      0, 0, 0, 8'h00, 0, 0, 1, 8'hBC);  // 56
    add(0, LO,      0, 0, 0, 8'h00, 0, 0, 0, 8'h50);

    // reset state
    @(posedge tx_clk); #1;
    chk("reset_out", -1, {txk, txd}, {1'b1, 8'hBC});
    chk("reset_ack", -1, {8'h00, mac_ack}, 9'h000);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      lacr_send = vecs[i].ls; lacr_out = vecs[i].lo; operate = vecs[i].op;
      rd_pos = vecs[i].rd; mac_tx_en = vecs[i].en; mac_txd = vecs[i].d;
      mac_tx_er = vecs[i].er;
      #1;
      chk("ack", i, {8'h00, mac_ack}, {8'h00, vecs[i].ack});
      @(posedge tx_clk); #1;
      chk("txd", i, {txk, txd}, {vecs[i].k, vecs[i].x});
    end

    // reset in the middle of a frame
    lacr_send = 1'b0; operate = 1'b1; mac_tx_en = 1'b1; mac_txd = 8'hAA;
    mac_tx_er = 1'b0;
    #1;
    chk("rstf_ack0", 100, {8'h00, mac_ack}, 9'h001);
    @(posedge tx_clk); #1;
    chk("rstf_s", 101, {txk, txd}, {1'b1, 8'hFB});
    mac_txd = 8'h12;
    #1;
    chk("rstf_ack1", 102, {8'h00, mac_ack}, 9'h001);
    rst = 1'b1;
    #1;
    chk("rstf_ackdrop", 103, {8'h00, mac_ack}, 9'h000);
    chk("rstf_out", 104, {txk, txd}, {1'b1, 8'hBC});
    @(posedge tx_clk); #1;
    rst = 1'b0;
    #1;
    chk("rstf_nogap", 105, {8'h00, mac_ack}, 9'h000);
    @(posedge tx_clk); #1;
    chk("rstf_i0", 106, {txk, txd}, {1'b1, 8'hBC});
    @(posedge tx_clk); #1;
    chk("rstf_i1", 107, {txk, txd}, {1'b0, 8'h50});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
